// File: rtl/rv32m_iter_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one accumulator pair, one bit per cycle.
module rv32m_iter_muldiv #(
   parameter int XLEN = 32,
   parameter int RD_W = 5,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [RD_W-1:0] in_rd,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [RD_W-1:0] out_rd,
   output logic [PC_W-1:0] out_pc,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] opb;
   logic [2:0]      op;
   logic            neg_q;
   logic            neg_r;

   logic            sign_a;
   logic            sign_b;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] special_res;

   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
      unique case (in_funct3)
         3'b001, 3'b100, 3'b110: begin
            sign_a = 1'b1;
            sign_b = 1'b1;
         end
         3'b010:  sign_a = 1'b1;
         default: ;
      endcase
   end

   assign a_neg    = sign_a & in_rs1[XLEN-1];
   assign b_neg    = sign_b & in_rs2[XLEN-1];
   assign a_mag    = a_neg ? -in_rs1 : in_rs1;
   assign b_mag    = b_neg ? -in_rs2 : in_rs2;
   assign div_zero = in_funct3[2] && (in_rs2 == '0);
   assign ovf      = in_funct3[2] && !in_funct3[0]
                     && (in_rs1 == MIN_VAL) && (in_rs2 == '1);

   always_comb begin
      if (div_zero)
         special_res = in_funct3[1] ? in_rs1 : '1;
      else
         special_res = in_funct3[1] ? '0 : in_rs1;
   end

   // One iteration: multiply shifts the product right, divide shifts left.
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_sh;
   logic [XLEN:0]   div_diff;
   logic            div_ge;
   logic [XLEN-1:0] acc_n;
   logic [XLEN-1:0] lo_n;

   assign mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
   assign div_sh   = {acc, lo[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_ge   = !div_diff[XLEN];

   always_comb begin
      if (op[2]) begin
         acc_n = div_ge ? div_diff[XLEN-1:0]
                        : {acc[XLEN-2:0], lo[XLEN-1]};
         lo_n  = {lo[XLEN-2:0], div_ge};
      end else begin
         acc_n = mul_sum[XLEN:1];
         lo_n  = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   result;

   assign prod   = {acc_n, lo_n};
   assign prod_s = neg_q ? -prod : prod;
   assign quo    = neg_q ? -lo_n : lo_n;
   assign rem    = neg_r ? -acc_n : acc_n;

   always_comb begin
      result = quo;
      unique case (1'b1)
         (op == 3'b000):        result = prod_s[XLEN-1:0];
         (!op[2] && op != '0):  result = prod_s[2*XLEN-1:XLEN];
         (op[2] && op[1]):      result = rem;
         default:               result = quo;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         lo       <= '0;
         opb      <= '0;
         op       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         out_data <= '0;
         out_rd   <= '0;
         out_pc   <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op     <= in_funct3;
                  out_rd <= in_rd;
                  out_pc <= in_pc;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  if (div_zero || ovf) begin
                     out_data <= special_res;
                     state    <= DONE;
                  end else begin
                     acc   <= '0;
                     lo    <= a_mag;
                     opb   <= b_mag;
                     cnt   <= CW'(XLEN-1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= acc_n;
               lo  <= lo_n;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  out_data <= result;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_rv32m_iter_muldiv.sv
// Scoreboard bench for rv32m_iter_muldiv: directed vectors, latency,
// backpressure, flush and asynchronous reset.
module tb_rv32m_iter_muldiv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [31:0] out_pc;
   logic        busy;

   rv32m_iter_muldiv dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_funct3 (in_funct3),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_pc    (out_pc),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                    name, act, req, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("latency", cyc, sb[0].cyc);
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("out_data", out_data, mon_e.data);
            chk("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
            chk("out_pc", out_pc, mon_e.pc);
         end
      end
      prev_v = out_valid;
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] ex,
                       input int lat, input bit push, output int acc);
      int n = 0;
      exp_t e;
      in_valid  = 1'b1;
      in_funct3 = f;
      in_rs1    = a;
      in_rs2    = b;
      in_rd     = rd;
      in_pc     = pc;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      acc = cyc;
      if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
      else if (push) begin
         e.data = ex;
         e.rd   = rd;
         e.pc   = pc;
         e.cyc  = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int acc2;
      int h;
      int n;
      logic saw;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_funct3 = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_rd     = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      send(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 32'h100, 32'hFFFFFFEB, 33, 1, acc);
      send(3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h104, 32'h40000000, 33, 1, acc);
      send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h108, 32'hFFFFFFFE, 33, 1, acc);
      send(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h10C, 32'hFFFFFFFF, 33, 1, acc);
      send(3'b100, 32'hFFFFFFF9, 32'd2, 5'd7, 32'h110, 32'hFFFFFFFD, 33, 1, acc);
      send(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8, 32'h114, 32'hFFFFFFFF, 33, 1, acc);
      send(3'b101, 32'd100, 32'd7, 5'd9, 32'h118, 32'd14, 33, 1, acc);
      send(3'b111, 32'd100, 32'd7, 5'd10, 32'h11C, 32'd2, 33, 1, acc);
      send(3'b100, 32'd5, 32'd0, 5'd11, 32'h120, 32'hFFFFFFFF, 1, 1, acc);
      send(3'b110, 32'd5, 32'd0, 5'd12, 32'h124, 32'd5, 1, 1, acc);
      send(3'b101, 32'd5, 32'd0, 5'd13, 32'h128, 32'hFFFFFFFF, 1, 1, acc);
      send(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h12C, 32'h80000000, 1, 1, acc);
      send(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h130, 32'd0, 1, 1, acc);
      drain();

      out_ready = 1'b0;
      send(3'b101, 32'd100, 32'd7, 5'd16, 32'h200, 32'd14, 33, 1, acc);
      in_valid  = 1'b1;
      in_funct3 = 3'b011;
      in_rs1    = 32'hFFFFFFFF;
      in_rs2    = 32'hFFFFFFFF;
      in_rd     = 5'd17;
      in_pc     = 32'h204;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", out_data, 32'd14);
         chk("bp_rd", {27'd0, out_rd}, 32'd16);
         chk("bp_pc", out_pc, 32'h200);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      h = cyc;
      send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'h204, 32'hFFFFFFFE, 33, 1, acc2);
      chk("bp_accept_cycle", acc2, h + 1);
      drain();

      send(3'b100, 32'd100, 32'd7, 5'd18, 32'h300, 32'd0, 33, 0, acc);
      while (cyc < acc + 10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         saw = saw | out_valid;
      end
      chk("flush_no_valid", {31'd0, saw}, 32'd0);
      @(posedge clk);
      #1;

      in_valid  = 1'b1;
      in_funct3 = 3'b100;
      in_rs1    = 32'd5;
      in_rs2    = 32'd0;
      in_rd     = 5'd19;
      in_pc     = 32'h304;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      chk("flush_idle_no_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_idle_no_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      send(3'b000, 32'd3, 32'd4, 5'd20, 32'h308, 32'd0, 33, 0, acc);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_out_rd", {27'd0, out_rd}, 32'd0);
      chk("arst_out_pc", out_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(3'b000, 32'd3, 32'd4, 5'd21, 32'h340, 32'd12, 33, 1, acc);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
